// File: rtl/fir_pkg.sv
// Shared FIR constants and types used by the sequencer, the datapath and their benches.
package fir_pkg;

  localparam int FIR_N_TAPS  = 2048;
  localparam int FIR_ADDR_W  = 11;
  localparam int FIR_MAC_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fir_state_e;

  // Accumulator framing bits travelling alongside each tap issue.
  typedef struct packed {
    logic clr;
    logic en;
    logic last;
  } acc_ctl_t;

endpackage

// File: rtl/fir_ctl_delay.sv
// Delays the accumulator framing bits so they line up with the product leaving the MAC pipe.
module fir_ctl_delay
  import fir_pkg::*;
#(
  parameter int DEPTH = FIR_MAC_LAT
) (
  input  logic     clk_fast,
  input  logic     resetn,
  input  acc_ctl_t ctl_d,
  output acc_ctl_t ctl_q
);

  acc_ctl_t pipe_q [DEPTH];

  always_ff @(posedge clk_fast or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= ctl_d;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign ctl_q = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for the single-MAC FIR: sample write, per-tap address issue, MAC framing, result strobe.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS  = FIR_N_TAPS,
  parameter int ADDR_W  = FIR_ADDR_W,
  parameter int MAC_LAT = FIR_MAC_LAT
) (
  input  logic              clk_fast,
  input  logic              resetn,
  input  logic              valid_in,
  input  logic              cload,
  input  logic [ADDR_W-1:0] caddr,
  output logic              in_rdy,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_waddr,
  output logic              sbuf_we,
  output logic [ADDR_W-1:0] sbuf_waddr,
  output logic [ADDR_W-1:0] coef_raddr,
  output logic [ADDR_W-1:0] smp_raddr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              acc_last,
  output logic              valid_out,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  fir_state_e        state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]     drain_q, drain_d;
  acc_ctl_t          issue_q, issue_d;
  logic              coef_we_q, coef_we_d;
  logic [ADDR_W-1:0] coef_waddr_q, coef_waddr_d;
  logic              sbuf_we_q, sbuf_we_d;
  logic [ADDR_W-1:0] sbuf_waddr_q, sbuf_waddr_d;
  logic [ADDR_W-1:0] smp_raddr_q, smp_raddr_d;
  logic              valid_out_q, valid_out_d;
  logic              in_rdy_q, in_rdy_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  acc_ctl_t          acc_ctl;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wr_ptr_d     = wr_ptr_q;
    drain_d      = drain_q;
    issue_d      = '0;
    coef_we_d    = 1'b0;
    coef_waddr_d = coef_waddr_q;
    sbuf_we_d    = 1'b0;
    valid_out_d  = 1'b0;
    overrun_d    = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cload) begin
          // Coefficient write has priority; a simultaneous sample is lost.
          coef_we_d    = 1'b1;
          coef_waddr_d = caddr;
          if (valid_in) overrun_d = 1'b1;
        end else if (valid_in) begin
          state_d   = ST_WRITE;
          sbuf_we_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RUN;
        k_d         = '0;
        issue_d.clr = 1'b1;
        issue_d.en  = 1'b1;
      end
      ST_RUN: begin
        if (k_q == ADDR_W'(N_TAPS - 1)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
          drain_d = '0;
        end else begin
          k_d          = k_q + 1'b1;
          issue_d.en   = 1'b1;
          issue_d.last = (k_d == ADDR_W'(N_TAPS - 1));
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(MAC_LAT - 1)) begin
          state_d     = ST_DONE;
          valid_out_d = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && (valid_in || cload)) overrun_d = 1'b1;

    // Newest sample sits at wr_ptr; tap k reads k samples back, wrapping modulo N_TAPS.
    sbuf_waddr_d = wr_ptr_d;
    smp_raddr_d  = wr_ptr_d - k_d;
    in_rdy_d     = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_fast or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      drain_q      <= '0;
      issue_q      <= '0;
      coef_we_q    <= 1'b0;
      coef_waddr_q <= '0;
      sbuf_we_q    <= 1'b0;
      sbuf_waddr_q <= '0;
      smp_raddr_q  <= '0;
      valid_out_q  <= 1'b0;
      in_rdy_q     <= 1'b1;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wr_ptr_q     <= wr_ptr_d;
      drain_q      <= drain_d;
      issue_q      <= issue_d;
      coef_we_q    <= coef_we_d;
      coef_waddr_q <= coef_waddr_d;
      sbuf_we_q    <= sbuf_we_d;
      sbuf_waddr_q <= sbuf_waddr_d;
      smp_raddr_q  <= smp_raddr_d;
      valid_out_q  <= valid_out_d;
      in_rdy_q     <= in_rdy_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  fir_ctl_delay #(.DEPTH(MAC_LAT)) u_ctl_delay (
    .clk_fast (clk_fast),
    .resetn   (resetn),
    .ctl_d    (issue_q),
    .ctl_q    (acc_ctl)
  );

  assign in_rdy     = in_rdy_q;
  assign coef_we    = coef_we_q;
  assign coef_waddr = coef_waddr_q;
  assign sbuf_we    = sbuf_we_q;
  assign sbuf_waddr = sbuf_waddr_q;
  assign coef_raddr = k_q;
  assign smp_raddr  = smp_raddr_q;
  assign acc_clr    = acc_ctl.clr;
  assign acc_en     = acc_ctl.en;
  assign acc_last   = acc_ctl.last;
  assign valid_out  = valid_out_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: stimulus queues expected events, a negedge monitor checks them.
module tb_fir_mac_sequencer;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int ML = 2;

  logic          clk_fast = 1'b0;
  logic          resetn   = 1'b0;
  logic          valid_in = 1'b0;
  logic          cload    = 1'b0;
  logic [AW-1:0] caddr    = '0;
  logic          overrun_clr = 1'b0;
  logic          in_rdy, coef_we, sbuf_we, acc_clr, acc_en, acc_last, valid_out, busy, overrun;
  logic [AW-1:0] coef_waddr, sbuf_waddr, coef_raddr, smp_raddr;

  fir_mac_sequencer #(.N_TAPS(N), .ADDR_W(AW), .MAC_LAT(ML)) dut (
    .clk_fast    (clk_fast),
    .resetn      (resetn),
    .valid_in    (valid_in),
    .cload       (cload),
    .caddr       (caddr),
    .in_rdy      (in_rdy),
    .coef_we     (coef_we),
    .coef_waddr  (coef_waddr),
    .sbuf_we     (sbuf_we),
    .sbuf_waddr  (sbuf_waddr),
    .coef_raddr  (coef_raddr),
    .smp_raddr   (smp_raddr),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .acc_last    (acc_last),
    .valid_out   (valid_out),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk_fast = ~clk_fast;

  int cyc = 0;
  always @(posedge clk_fast) cyc <= cyc + 1;

  typedef struct {
    int k;
    int s;
    int at;
  } tap_t;

  int   q_coef[$];
  int   q_sbuf[$];
  int   q_vout[$];
  tap_t q_tap[$];

  int checks = 0;
  int errors = 0;
  int wp = 0;
  int busy_until = 0;
  bit ov = 0;
  bit mon_en = 0;
  int h_c[16];
  int h_s[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: strobe seen with nothing expected", name, cyc);
  endtask

  // Reference model: request acceptance, expected strobes and the sticky flag, from the rules directly.
  task automatic model_edge(input bit v, input bit c, input int a, input bit oc);
    int  e;
    bit  idle;
    bit  set_ov;
    e      = cyc;
    idle   = (e > busy_until);
    set_ov = 1'b0;
    if (idle && c) begin
      q_coef.push_back(a);
      if (v) set_ov = 1'b1;
    end else if (idle && v) begin
      q_sbuf.push_back(wp);
      for (int k = 0; k < N; k++) q_tap.push_back('{k: k, s: (wp - k + N) % N, at: e + 1 + k});
      q_vout.push_back(e + N + ML + 1);
      busy_until = e + N + ML + 2;
      wp = (wp + 1) % N;
    end else if (!idle && (v || c)) begin
      set_ov = 1'b1;
    end
    if (set_ov) ov = 1'b1;
    else if (oc) ov = 1'b0;
  endtask

  task automatic step(input bit v, input bit c, input int a, input bit oc);
    valid_in    = v;
    cload       = c;
    caddr       = a[AW-1:0];
    overrun_clr = oc;
    @(posedge clk_fast);
    #1;
    model_edge(v, c, a, oc);
    valid_in    = 1'b0;
    cload       = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!in_rdy && n < 40) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (!in_rdy) unexp("in_rdy_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_coef_we"},    coef_we,    0);
    chk({tag, "_coef_waddr"}, coef_waddr, 0);
    chk({tag, "_sbuf_we"},    sbuf_we,    0);
    chk({tag, "_sbuf_waddr"}, sbuf_waddr, 0);
    chk({tag, "_coef_raddr"}, coef_raddr, 0);
    chk({tag, "_smp_raddr"},  smp_raddr,  0);
    chk({tag, "_acc"},        {acc_clr, acc_en, acc_last}, 0);
    chk({tag, "_valid_out"},  valid_out,  0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_overrun"},    overrun,    0);
    chk({tag, "_in_rdy"},     in_rdy,     1);
  endtask

  task automatic release_reset();
    q_coef.delete();
    q_sbuf.delete();
    q_vout.delete();
    q_tap.delete();
    wp = 0;
    ov = 1'b0;
    resetn = 1'b1;
    busy_until = cyc;
    mon_en = 1'b1;
  endtask

  always @(negedge clk_fast) begin
    if (mon_en) begin
      tap_t t;
      h_c[cyc & 15] = int'(coef_raddr);
      h_s[cyc & 15] = int'(smp_raddr);
      chk("in_rdy", in_rdy, cyc >= busy_until);
      chk("busy",   busy,   cyc < busy_until);
      chk("overrun", overrun, ov);
      if (coef_we) begin
        if (q_coef.size() == 0) unexp("coef_we");
        else chk("coef_waddr", coef_waddr, q_coef.pop_front());
      end
      if (sbuf_we) begin
        if (q_sbuf.size() == 0) unexp("sbuf_we");
        else chk("sbuf_waddr", sbuf_waddr, q_sbuf.pop_front());
      end
      if (acc_en) begin
        if (q_tap.size() == 0) unexp("acc_en");
        else begin
          t = q_tap.pop_front();
          chk("tap_issue_cycle", cyc - ML, t.at);
          chk("coef_raddr", h_c[(cyc - ML) & 15], t.k);
          chk("smp_raddr",  h_s[(cyc - ML) & 15], t.s);
          chk("acc_clr",  acc_clr,  t.k == 0);
          chk("acc_last", acc_last, t.k == N - 1);
        end
      end else if (acc_clr || acc_last) begin
        unexp("acc_clr_last_without_en");
      end
      if (valid_out) begin
        if (q_vout.size() == 0) unexp("valid_out");
        else chk("valid_out_cycle", cyc, q_vout.pop_front());
      end
    end
  end

  initial begin
    // Power-on reset.
    repeat (3) @(posedge clk_fast);
    #1;
    chk_reset_outputs("rst_hold");
    release_reset();
    #1;
    chk_reset_outputs("rst_rel");

    // Coefficient load on consecutive cycles.
    for (int i = 0; i < N; i++) step(0, 1, i, 0);
    idle_steps(3);

    // Single sample, then let it complete.
    step(1, 0, 0, 0);
    idle_steps(N + ML + 4);

    // Sample dropped while running; sticky until cleared.
    step(1, 0, 0, 0);
    idle_steps(2);
    step(1, 0, 0, 0);
    idle_steps(3);
    step(0, 1, 3, 0);
    wait_rdy();
    idle_steps(2);
    step(0, 0, 0, 1);
    idle_steps(2);
    step(1, 1, 2, 0);
    idle_steps(2);
    step(0, 0, 0, 1);

    // Asynchronous reset in the middle of a convolution.
    wait_rdy();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    idle_steps(2);
    #2;
    resetn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk_reset_outputs("rst_midrun");
    @(posedge clk_fast);
    @(posedge clk_fast);
    #1;
    release_reset();
    idle_steps(N + ML + 6);

    // Back-to-back samples walk the write pointer through the wrap.
    for (int i = 0; i < 5; i++) begin
      wait_rdy();
      step(1, 0, 0, 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
           int'($urandom_range(0, N - 1)), $urandom_range(0, 99) < 6);
    end

    idle_steps(N + ML + 6);
    chk("q_coef_empty", q_coef.size(), 0);
    chk("q_sbuf_empty", q_sbuf.size(), 0);
    chk("q_tap_empty",  q_tap.size(),  0);
    chk("q_vout_empty", q_vout.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Control FSM that sequences the single-MAC FIR datapath in the fast clock domain. For each accepted input sample it writes the sample into the circular delay-line buffer. It then issues one coefficient-read/sample-read pair per tap, frames the accumulator (clear/enable/last), waits out the MAC pipeline and pulses valid_out. It also gates coefficient-RAM writes, so coefficients are never rewritten during a convolution.

Parameters:
N_TAPS, 2048, number of taps; power of two, >= 4
ADDR_W, 11, log2(N_TAPS); width of all buffer/RAM addresses
MAC_LAT, 2, MAC pipeline depth in cycles between issuing a tap and its product being accumulated

Ports:
clk_fast  in  1  single clock
resetn  in  1  asynchronous, active-low reset
valid_in  in  1  one-cycle sample strobe; din is captured by the datapath on sbuf_we
cload  in  1  coefficient write request
caddr  in  ADDR_W  coefficient write address
in_rdy  out  1  high only in IDLE; valid_in/cload are accepted only when in_rdy=1
coef_we  out  1  coefficient RAM write enable, registered, one cycle
coef_waddr  out  ADDR_W  registered copy of caddr
sbuf_we  out  1  sample buffer write enable
sbuf_waddr  out  ADDR_W  write pointer wr_ptr
coef_raddr  out  ADDR_W  tap index k
smp_raddr  out  ADDR_W  (wr_ptr - k) mod N_TAPS
acc_clr  out  1  high with the k=0 issue, delayed MAC_LAT
acc_en  out  1  high for each tap issue, delayed MAC_LAT
valid_out  out  1  one-cycle result-valid pulse
busy  out  1  not IDLE
overrun  out  1  sticky: a request was dropped
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, resetn=0): state=IDLE, wr_ptr=0, k=0, overrun=0. All other outputs 0, except in_rdy=1.
- All outputs are registered.
- States: IDLE, WRITE, RUN, DRAIN, DONE.
- IDLE, cload=1 at edge: coef_we=1 and coef_waddr=caddr for the next cycle; state stays IDLE.
- IDLE, valid_in=1 and cload=0 at edge t: state -> WRITE; sbuf_we=1 and sbuf_waddr=wr_ptr during cycle t..t+1.
- IDLE, cload and valid_in both high at the same edge: the coefficient write wins; the sample is dropped and overrun is set.
- WRITE -> RUN at edge t+1; k=0.
- RUN: one tap per cycle for k=0..N_TAPS-1, with acc_en-issue pulsing each cycle. After k=N_TAPS-1 the state goes to DRAIN; k wraps to 0.
- acc_clr/acc_en/acc_last timing: delayed by MAC_LAT from the issue, so they align with the product arriving at the accumulator.
- DRAIN: lasts MAC_LAT cycles, then DONE.
- DONE: valid_out=1 for exactly one cycle; wr_ptr increments mod N_TAPS; state -> IDLE.
- valid_in or cload while in_rdy=0: request dropped, no side effects, overrun set. overrun_clr clears it; set wins if both occur at the same edge.
- Latency: valid_in accepted at edge t -> valid_out high in the cycle after edge t+N_TAPS+MAC_LAT+1. The next request can be accepted at edge t+N_TAPS+MAC_LAT+2.
- wr_ptr wraps from N_TAPS-1 to 0. smp_raddr uses modular ADDR_W-bit subtraction, no sign extension.
- resetn asserted mid-convolution: immediate abort to reset values; no valid_out is emitted.

Decomposition:
- Shared package fir_pkg holds the state enum, N_TAPS/ADDR_W defaults and MAC_LAT. The existing fir_filter testbench and datapath import the same constants.
- One natural sub-module: fir_ctl_delay. It is a MAC_LAT-deep shift register that carries {acc_clr, acc_en, acc_last}.

Test Plan:
(All scenarios use N_TAPS=4, ADDR_W=2, MAC_LAT=2.)
- Reset check: assert resetn=0 mid-RUN -> all outputs go to 0 at once, in_rdy=1, and no valid_out follows after release.
- Coefficient load: cload with caddr=0..3 in IDLE on consecutive cycles -> coef_we pulses 4 times with coef_waddr 0,1,2,3; busy stays 0.
- Single sample: valid_in at edge 10 ->
  - sbuf_we with waddr 0 in cycle 10;
  - coef_raddr 0,1,2,3 paired with smp_raddr 0,3,2,1 on edges 11-14;
  - acc_clr aligned to edge 13;
  - valid_out in the cycle after edge 17;
  - in_rdy returns at edge 18.
- Wrap: five back-to-back samples -> sbuf_waddr runs 0,1,2,3,0. On the fifth sample smp_raddr runs 0,3,2,1.
- Overrun: valid_in during RUN -> dropped, overrun=1 and it stays sticky. overrun_clr clears it. cload+valid_in together in IDLE -> coef_we=1, sample dropped, overrun=1.
